// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation arbiter: opcode/data widths,
// arbiter state encoding and the opcode constants understood by the ALU
// op-select decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Opcodes decoded by the ALU op-select decoder
    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_AND = 4'h4;
    localparam logic [OP_W-1:0] OP_OR  = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR = 4'h6;

    // Index width needed to address n requesters (at least 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_op_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr_i, wrapping from NREQ-1 back to 0.
// Ports:
//   req_i  [NREQ-1:0]  request vector
//   ptr_i  [IW-1:0]    search start index (must be < NREQ)
//   gnt_o  [NREQ-1:0]  one-hot winner (all zero when no request)
//   idx_o  [IW-1:0]    winner index (0 when no request)
//   any_o              at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr_i < NREQ and i < NREQ, so one subtraction is enough to wrap
            j = int'(ptr_i) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// ---------------------------------------------------------------------------
// alu_op_arbiter
// Shares one 32-bit ALU among NREQ requesters. A round-robin winner is picked
// in IDLE, its opcode/operands are latched and presented to the ALU for
// ALU_LAT cycles (EXEC), the result is captured and returned with a one-cycle
// rsp_valid pulse to the owner (RESP). This block is the only driver of the
// ALU decoder enable.
//
// Optional feature macro: ALU_ARB_PRIO_EN
//   defined     : requester 0 has fixed top priority; round-robin over
//                 1..NREQ-1 only; rr pointer not advanced on a requester-0 grant
//   not defined : pure round-robin over all NREQ requesters
//
// Handshake: a requester raises req[i] with req_op/req_a/req_b stable and
// holds it until gnt[i] pulses (operands latched), then drops req[i] the next
// cycle. Requests are only sampled in IDLE; the result for requester i comes
// back as a one-cycle rsp_valid[i] pulse with rsp_data valid in that cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req     [NREQ-1:0]    request per requester
//   req_op  [4*NREQ-1:0]  opcode of requester i at [4i+3:4i]
//   req_a   [32*NREQ-1:0] operand A of requester i at [32i+31:32i]
//   req_b   [32*NREQ-1:0] operand B of requester i at [32i+31:32i]
//   gnt     [NREQ-1:0]    one-hot 1-cycle pulse: operands latched
//   rsp_valid [NREQ-1:0]  one-hot 1-cycle pulse: rsp_data valid
//   rsp_data [31:0]       captured ALU result (holds until next capture)
//   busy                  state != IDLE
//   alu_en, alu_op, alu_a, alu_b  ALU decoder/operand drive (0 outside EXEC)
//   alu_result [31:0]     ALU result
// ---------------------------------------------------------------------------
module alu_op_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [OP_W*NREQ-1:0]   req_op,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   busy,
    output logic                   alu_en,
    output logic [OP_W-1:0]        alu_op,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    input  logic [DATA_W-1:0]      alu_result
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = 4;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   pick_req, pick_oh, win_oh;
    logic [IW-1:0]     pick_idx, win_idx;
    logic              pick_any, win_any;
    logic              advance_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i (pick_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Winner selection (priority override for requester 0 when enabled)
    always_comb begin
`ifdef ALU_ARB_PRIO_EN
        // Requester 0 is removed from the rotation and wins outright.
        pick_req = req & ~ONE_HOT0;
        if (req[0]) begin
            win_any = 1'b1;
            win_oh  = ONE_HOT0;
            win_idx = '0;
        end else begin
            win_any = pick_any;
            win_oh  = pick_oh;
            win_idx = pick_idx;
        end
        advance_ptr = (owner_q != '0);
`else
        pick_req    = req;
        win_any     = pick_any;
        win_oh      = pick_oh;
        win_idx     = pick_idx;
        advance_ptr = 1'b1;
`endif
    end

    // Next-state and register-update logic
    always_comb begin
        int sel;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        sel         = int'(win_idx);

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    owner_d = win_idx;
                    op_d    = req_op[sel*OP_W +: OP_W];
                    a_d     = req_a[sel*DATA_W +: DATA_W];
                    b_d     = req_b[sel*DATA_W +: DATA_W];
                    gnt_d   = win_oh;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CW'(ALU_LAT - 1)) begin
                    rsp_data_d = alu_result;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                // rsp_valid is registered, so the pulse lands in the cycle
                // after RESP, ALU_LAT+1 cycles after the grant pulse.
                rsp_valid_d = ONE_HOT0 << owner_q;
                if (advance_ptr) begin
                    rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            owner_q     <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // ALU drive is gated by state so it falls to zero as soon as reset hits
    assign alu_en    = (state_q == ST_EXEC);
    assign alu_op    = alu_en ? op_q : '0;
    assign alu_a     = alu_en ? a_q  : '0;
    assign alu_b     = alu_en ? b_q  : '0;
    assign busy      = (state_q != ST_IDLE);
    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
